// File: rtl/bmp_frame_writer.sv
// BMP pixel stream to RGB565 frame-buffer writer with address generation and a FWFT beat FIFO.
// Define BMP_ROW_FLIP_EN for bottom-up (BMP file order) row addressing; default is row-major.
module bmp_frame_writer #(
    parameter int unsigned H_ACTIVE   = 1024,
    parameter int unsigned V_ACTIVE   = 768,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned ADDR_W     = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              write_req_i,
    output logic              write_req_ack_o,
    input  logic              bmp_data_wr_en_i,
    input  logic [23:0]       bmp_data_i,
    output logic              mem_wr_en_o,
    input  logic              mem_wr_ready_i,
    output logic [ADDR_W-1:0] mem_wr_addr_o,
    output logic [15:0]       mem_wr_data_o,
    output logic              frame_done_o,
    output logic              overflow_o
);

    localparam int unsigned PixCount = H_ACTIVE * V_ACTIVE;
    localparam int unsigned ColW     = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int unsigned PixW     = $clog2(PixCount + 1);
    localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW     = PtrW + 1;

    localparam logic [ColW-1:0]   ColMax  = ColW'(H_ACTIVE - 1);
    localparam logic [PixW-1:0]   PixLast = PixW'(PixCount - 1);
    localparam logic [CntW-1:0]   CntFull = CntW'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] HStep   = ADDR_W'(H_ACTIVE);

    typedef enum logic [2:0] {StIdle, StAck, StRecv, StDrain, StDone} state_e;

    state_e            state_q, state_d;
    logic [ColW-1:0]   col_q, col_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d, row_base_step;
    logic [PixW-1:0]   pix_cnt_q, pix_cnt_d;

    logic              stg_vld_q;
    logic [15:0]       stg_data_q;
    logic [ADDR_W-1:0] stg_addr_q;

    logic [15:0]       data_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              overflow_q;

    logic accept, flush, ack, done, push, pop, drop, fifo_full, fifo_empty;

`ifdef BMP_ROW_FLIP_EN
    localparam logic [ADDR_W-1:0] RowBaseInit = ADDR_W'((V_ACTIVE - 1) * H_ACTIVE);
    assign row_base_step = row_base_q - HStep;
`else
    localparam logic [ADDR_W-1:0] RowBaseInit = '0;
    assign row_base_step = row_base_q + HStep;
`endif

    // Only the RGB565-significant bits of each channel are kept.
    logic unused_pix_lsbs;
    assign unused_pix_lsbs = ^{bmp_data_i[18:16], bmp_data_i[9:8], bmp_data_i[2:0]};

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CntFull);
    assign pop        = !fifo_empty && mem_wr_ready_i && !flush;
    assign push       = stg_vld_q && !flush && (!fifo_full || pop);
    assign drop       = stg_vld_q && !flush && fifo_full && !pop;

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_base_d = row_base_q;
        pix_cnt_d  = pix_cnt_q;
        accept     = 1'b0;
        flush      = 1'b0;
        ack        = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (write_req_i) state_d = StAck;
            end
            StAck: begin
                ack        = 1'b1;
                flush      = 1'b1;
                col_d      = '0;
                row_base_d = RowBaseInit;
                pix_cnt_d  = '0;
                state_d    = StRecv;
            end
            StRecv: begin
                if (write_req_i) begin
                    flush   = 1'b1;
                    state_d = StAck;
                end else if (bmp_data_wr_en_i) begin
                    accept    = 1'b1;
                    pix_cnt_d = pix_cnt_q + PixW'(1);
                    if (col_q == ColMax) begin
                        col_d      = '0;
                        row_base_d = row_base_step;
                    end else begin
                        col_d = col_q + ColW'(1);
                    end
                    if (pix_cnt_q == PixLast) state_d = StDrain;
                end
            end
            StDrain: begin
                if (write_req_i) begin
                    flush   = 1'b1;
                    state_d = StAck;
                end else if (fifo_empty && !stg_vld_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + CntW'(1);
        else if (pop && !push) cnt_d = cnt_q - CntW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            col_q      <= '0;
            row_base_q <= '0;
            pix_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_base_q <= row_base_d;
            pix_cnt_q  <= pix_cnt_d;
        end
    end

    // Conversion/address stage: one register between accept and the FIFO write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stg_vld_q  <= 1'b0;
            stg_data_q <= '0;
            stg_addr_q <= '0;
        end else begin
            stg_vld_q <= accept;
            if (accept) begin
                stg_data_q <= {bmp_data_i[23:19], bmp_data_i[15:10], bmp_data_i[7:3]};
                stg_addr_q <= row_base_q + ADDR_W'(col_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= stg_data_q;
            addr_mem[wr_ptr_q] <= stg_addr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || state_q == StAck) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end
    end

    assign write_req_ack_o = ack;
    assign frame_done_o    = done;
    assign overflow_o      = overflow_q;
    assign mem_wr_en_o     = !fifo_empty;
    assign mem_wr_addr_o   = fifo_empty ? '0 : addr_mem[rd_ptr_q];
    assign mem_wr_data_o   = fifo_empty ? '0 : data_mem[rd_ptr_q];

endmodule

// File: tb/tb_bmp_frame_writer.sv
// Randomized bench for bmp_frame_writer: queue-based reference model checked every cycle,
// plus directed frames pinned to hand-computed beat addresses and data.
module tb_bmp_frame_writer;

    localparam int unsigned H  = 4;
    localparam int unsigned V  = 2;
    localparam int unsigned D  = 4;
    localparam int unsigned AW = 24;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          write_req = 1'b0;
    logic          wr_en = 1'b0;
    logic [23:0]   pix = '0;
    logic          mem_wr_ready = 1'b0;
    logic          ack, en, done, ovf;
    logic [AW-1:0] addr;
    logic [15:0]   data;

    bit rand_ready = 1'b0;
    bit ready_fix  = 1'b1;

    always #5 clk = ~clk;

    bmp_frame_writer #(
        .H_ACTIVE  (H),
        .V_ACTIVE  (V),
        .FIFO_DEPTH(D),
        .ADDR_W    (AW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .write_req_i     (write_req),
        .write_req_ack_o (ack),
        .bmp_data_wr_en_i(wr_en),
        .bmp_data_i      (pix),
        .mem_wr_en_o     (en),
        .mem_wr_ready_i  (mem_wr_ready),
        .mem_wr_addr_o   (addr),
        .mem_wr_data_o   (data),
        .frame_done_o    (done),
        .overflow_o      (ovf)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] to565(input logic [23:0] p);
        return {p[23:19], p[15:10], p[7:3]};
    endfunction

    // Frame-buffer address of the idx-th pixel of the file.
    function automatic logic [AW-1:0] pix_addr(input int idx);
        int row = idx / int'(H);
        int col = idx % int'(H);
`ifdef BMP_ROW_FLIP_EN
        return AW'((int'(V) - 1 - row) * int'(H) + col);
`else
        return AW'(row * int'(H) + col);
`endif
    endfunction

    // Reference model: frame phase flags, one in-flight converted pixel, beat queue.
    logic [AW+15:0] fq[$];
    logic [AW+15:0] stg = '0;
    bit  stg_v = 0, m_ack = 0, m_recv = 0, m_drain = 0, m_done = 0, m_ovf = 0;
    int  pix_idx = 0;
    bit  rst_seen = 0;

    int            ack_cnt = 0, done_cnt = 0;
    logic [AW-1:0] addr_log[$];
    logic [15:0]   data_log[$];

    always @(posedge clk) if (!rst_n) rst_seen <= 1'b1;

    always @(posedge clk) begin
        #2;
        mem_wr_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fix;
    end

    always @(negedge clk) begin
        bit exp_en, pop, abort, n_ack, n_recv, n_drain, n_done, n_stg_v;
        logic [AW+15:0] n_stg;
        if (rst_seen) begin
            exp_en = (fq.size() != 0);
            chk("mem_wr_en", 32'(en), 32'(exp_en));
            if (exp_en) begin
                chk("mem_wr_addr", 32'(addr), 32'(fq[0][AW+15:16]));
                chk("mem_wr_data", 32'(data), 32'(fq[0][15:0]));
            end
            chk("write_req_ack", 32'(ack), 32'(m_ack));
            chk("frame_done", 32'(done), 32'(m_done));
            chk("overflow", 32'(ovf), 32'(m_ovf));
            if (ack) ack_cnt++;
            if (done) done_cnt++;
            if (en && mem_wr_ready) begin
                addr_log.push_back(addr);
                data_log.push_back(data);
            end
        end
        if (!rst_n) begin
            fq.delete();
            stg_v = 0; m_ack = 0; m_recv = 0; m_drain = 0; m_done = 0; m_ovf = 0;
            pix_idx = 0;
        end else begin
            exp_en = (fq.size() != 0);
            pop    = exp_en && mem_wr_ready;
            abort  = write_req && (m_recv || m_drain);
            n_ack = 0; n_recv = 0; n_drain = 0; n_done = 0; n_stg_v = 0; n_stg = '0;
            if (m_ack) begin
                n_recv  = 1;
                pix_idx = 0;
            end else if (m_done) begin
                n_done = 0;
            end else if (abort) begin
                n_ack = 1;
            end else if (m_recv) begin
                n_recv = 1;
                if (wr_en) begin
                    n_stg   = {pix_addr(pix_idx), to565(pix)};
                    n_stg_v = 1;
                    pix_idx++;
                    if (pix_idx == int'(H * V)) begin
                        n_recv  = 0;
                        n_drain = 1;
                    end
                end
            end else if (m_drain) begin
                if (fq.size() == 0 && !stg_v) n_done = 1;
                else n_drain = 1;
            end else if (write_req) begin
                n_ack = 1;
            end
            if (abort || m_ack) begin
                fq.delete();
                if (m_ack) m_ovf = 0;
            end else begin
                if (pop) void'(fq.pop_front());
                if (stg_v) begin
                    if (fq.size() >= int'(D)) m_ovf = 1;
                    else fq.push_back(stg);
                end
            end
            stg = n_stg; stg_v = n_stg_v;
            m_ack = n_ack; m_recv = n_recv; m_drain = n_drain; m_done = n_done;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int n, input logic [23:0] val, input bit rnd);
        int sent = 0;
        while (sent < n) begin
            if (rnd && $urandom_range(0, 3) == 0) begin
                wr_en = 1'b0;
            end else begin
                wr_en = 1'b1;
                pix   = rnd ? 24'($urandom) : val;
                sent++;
            end
            cyc();
        end
        wr_en = 1'b0;
    endtask

    task automatic start_frame();
        write_req = 1'b1;
        cyc();
        write_req = 1'b0;
        cyc();
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) cyc();
        chk("frame_done_seen", 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic check_log(input string name, input int n, input logic [AW-1:0] ea [8],
                             input logic [15:0] ed);
        chk({name, "_beats"}, 32'(addr_log.size()), 32'(n));
        for (int i = 0; i < n && i < addr_log.size(); i++) begin
            chk({name, "_addr"}, 32'(addr_log[i]), 32'(ea[i]));
            chk({name, "_data"}, 32'(data_log[i]), 32'(ed));
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] full_a [8];
        logic [AW-1:0] ovf_a  [8];
        int a0, d0;
`ifdef BMP_ROW_FLIP_EN
        full_a = '{24'd4, 24'd5, 24'd6, 24'd7, 24'd0, 24'd1, 24'd2, 24'd3};
        ovf_a  = '{24'd4, 24'd5, 24'd6, 24'd7, 24'd2, 24'd3, 24'd0, 24'd0};
`else
        full_a = '{24'd0, 24'd1, 24'd2, 24'd3, 24'd4, 24'd5, 24'd6, 24'd7};
        ovf_a  = '{24'd0, 24'd1, 24'd2, 24'd3, 24'd6, 24'd7, 24'd0, 24'd0};
`endif
        // Reset with request and pixel valid held high.
        rst_n = 1'b0; write_req = 1'b1; wr_en = 1'b1; pix = 24'hFFFFFF;
        cyc(); cyc();
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_en", 32'(en), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        write_req = 1'b0; wr_en = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("idle_ack", 32'(ack), 32'd0);

        // Red frame, always ready.
        ready_fix = 1'b1;
        addr_log.delete(); data_log.delete();
        a0 = ack_cnt; d0 = done_cnt;
        start_frame();
        send(8, 24'hFF0000, 1'b0);
        wait_done(50);
        check_log("red", 8, full_a, 16'hF800);
        chk("red_acks", 32'(ack_cnt - a0), 32'd1);
        cyc(); cyc();
        chk("red_done_count", 32'(done_cnt - d0), 32'd1);

        // Green frame.
        addr_log.delete(); data_log.delete();
        start_frame();
        send(8, 24'h00FF00, 1'b0);
        wait_done(50);
        check_log("green", 8, full_a, 16'h07E0);

        // Overflow: six pixels into a four-deep FIFO with the sink stalled.
        ready_fix = 1'b0;
        cyc();
        addr_log.delete(); data_log.delete();
        start_frame();
        send(6, 24'h0000FF, 1'b0);
        cyc(); cyc(); cyc();
        chk("ovf_flag", 32'(ovf), 32'd1);
        chk("ovf_en_stalled", 32'(en), 32'd1);
        ready_fix = 1'b1;
        repeat (8) cyc();
        send(2, 24'h0000FF, 1'b0);
        wait_done(50);
        check_log("ovf", 6, ovf_a, 16'h001F);

        // Abort with overflow set, then abort after 3 pixels, then a full frame.
        ready_fix = 1'b0;
        cyc();
        a0 = ack_cnt; d0 = done_cnt;
        start_frame();
        send(6, 24'h123456, 1'b0);
        cyc();
        chk("abort_ovf_before", 32'(ovf), 32'd1);
        write_req = 1'b1;
        cyc();
        write_req = 1'b0;
        chk("abort_ack", 32'(ack), 32'd1);
        chk("abort_en_dropped", 32'(en), 32'd0);
        cyc();
        chk("abort_ovf_cleared", 32'(ovf), 32'd0);
        rand_ready = 1'b1;
        send(3, 24'h0, 1'b1);
        write_req = 1'b1;
        cyc();
        write_req = 1'b0;
        cyc();
        send(8, 24'h0, 1'b1);
        wait_done(200);
        chk("abort_acks", 32'(ack_cnt - a0), 32'd3);
        chk("abort_dones", 32'(done_cnt - d0), 32'd1);

        // Random frames with random stalls and pixel gaps.
        for (int f = 0; f < 8; f++) begin
            repeat ($urandom_range(0, 3)) cyc();
            start_frame();
            send(8, 24'h0, 1'b1);
            wait_done(200);
        end
        rand_ready = 1'b0;
        repeat (4) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
